// File: rtl/cgra_exec_ctrl_if.sv
// cgra_exec_ctrl_if
// Bundles the software-facing launch/completion handshake and the PE-array
// control signals of the CGRA execution controller.
//   master : software / array side (drives start, iteration setup, busy)
//   slave  : cgra_exec_ctrl (drives run, iteration pulse, base address, done)
// Signals:
//   Computation_Start  level launch request
//   Iter_Num/Iter_Len  iteration count / cycles per iteration (CNT_WIDTH)
//   Iter_Stride        BRAM address increment per iteration (SYS_DWIDTH)
//   PE_Array_Busy      torus still has operations in flight
//   PE_Array_Run       PE array enable
//   Iter_Start         first-cycle-of-iteration pulse
//   Addr_Base          BRAM base address of current iteration
//   Computation_Done   level completion flag
//   Timeout_Err        drain watchdog expired
interface cgra_exec_ctrl_if #(
  parameter int SYS_DWIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  Computation_Start;
  logic [CNT_WIDTH-1:0]  Iter_Num;
  logic [CNT_WIDTH-1:0]  Iter_Len;
  logic [SYS_DWIDTH-1:0] Iter_Stride;
  logic                  PE_Array_Busy;
  logic                  PE_Array_Run;
  logic                  Iter_Start;
  logic [SYS_DWIDTH-1:0] Addr_Base;
  logic                  Computation_Done;
  logic                  Timeout_Err;

  modport master (
    output Computation_Start, Iter_Num, Iter_Len, Iter_Stride, PE_Array_Busy,
    input  PE_Array_Run, Iter_Start, Addr_Base, Computation_Done, Timeout_Err
  );

  modport slave (
    input  Computation_Start, Iter_Num, Iter_Len, Iter_Stride, PE_Array_Busy,
    output PE_Array_Run, Iter_Start, Addr_Base, Computation_Done, Timeout_Err
  );
endinterface

// File: rtl/cgra_exec_ctrl.sv
// cgra_exec_ctrl
// Sequences a CGRA kernel: runs Iter_Num iterations of max(Iter_Len,1)
// cycles each, stepping the BRAM base address by Iter_Stride per iteration,
// then waits for the PE array to drain before raising Computation_Done.
// Dropping Computation_Start during RUN or DRAIN aborts back to IDLE.
// Ports:
//   Clk     sole clock, rising edge
//   Resetn  asynchronous active-low reset
//   bus     cgra_exec_ctrl_if.slave (handshake, iteration setup, array control)
// Optional feature: define CGRA_TIMEOUT_EN to add a drain watchdog that
// forces DONE with Timeout_Err=1 after TIMEOUT_CYC busy DRAIN cycles.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for Computation_Start; latches iteration setup
// ST_RUN   | PE array enabled, iterating
// ST_DRAIN | iterations finished, waiting for PE_Array_Busy=0
// ST_DONE  | Computation_Done high until Computation_Start drops
module cgra_exec_ctrl #(
  parameter int SYS_DWIDTH  = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic             Clk,
  input logic             Resetn,
  cgra_exec_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  len_m1_q;
  logic [CNT_WIDTH-1:0]  len_cnt;
  logic [CNT_WIDTH-1:0]  iter_cnt;
  logic [SYS_DWIDTH-1:0] stride_q;
  logic [SYS_DWIDTH-1:0] addr_q;
  logic                  iter_start_q;
  logic [CNT_WIDTH-1:0]  len_m1_in;
  logic                  iter_last;

  // Iteration length is held as a terminal-count reload value; zero length
  // behaves as a single-cycle iteration.
  assign len_m1_in = (bus.Iter_Len == '0) ? '0 : bus.Iter_Len - CNT_WIDTH'(1);
  assign iter_last = (iter_cnt == num_q - CNT_WIDTH'(1));

`ifdef CGRA_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            terr_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state        <= ST_IDLE;
      num_q        <= '0;
      len_m1_q     <= '0;
      len_cnt      <= '0;
      iter_cnt     <= '0;
      stride_q     <= '0;
      addr_q       <= '0;
      iter_start_q <= 1'b0;
`ifdef CGRA_TIMEOUT_EN
      wd_cnt       <= '0;
      terr_q       <= 1'b0;
`endif
    end else begin
      iter_start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.Computation_Start) begin
            num_q    <= bus.Iter_Num;
            len_m1_q <= len_m1_in;
            stride_q <= bus.Iter_Stride;
            len_cnt  <= len_m1_in;
            iter_cnt <= '0;
            addr_q   <= '0;
            if (bus.Iter_Num != '0) begin
              state        <= ST_RUN;
              iter_start_q <= 1'b1;
            end else begin
              state <= ST_DONE;
            end
          end
        end

        ST_RUN: begin
          if (!bus.Computation_Start) begin
            state  <= ST_IDLE;
            addr_q <= '0;
          end else if (len_cnt != '0) begin
            len_cnt <= len_cnt - CNT_WIDTH'(1);
          end else if (iter_last) begin
            state <= ST_DRAIN;
`ifdef CGRA_TIMEOUT_EN
            wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
`endif
          end else begin
            // Back-to-back iterations: reload and step address with no gap.
            iter_cnt     <= iter_cnt + CNT_WIDTH'(1);
            addr_q       <= addr_q + stride_q;
            len_cnt      <= len_m1_q;
            iter_start_q <= 1'b1;
          end
        end

        ST_DRAIN: begin
          if (!bus.Computation_Start) begin
            state  <= ST_IDLE;
            addr_q <= '0;
          end else if (!bus.PE_Array_Busy) begin
            state <= ST_DONE;
          end
`ifdef CGRA_TIMEOUT_EN
          else if (wd_cnt == '0) begin
            state  <= ST_DONE;
            terr_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
          end
`endif
        end

        ST_DONE: begin
          if (!bus.Computation_Start) begin
            state <= ST_IDLE;
`ifdef CGRA_TIMEOUT_EN
            terr_q <= 1'b0;
`endif
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.PE_Array_Run     = (state == ST_RUN);
  assign bus.Iter_Start       = iter_start_q;
  assign bus.Addr_Base        = addr_q;
  assign bus.Computation_Done = (state == ST_DONE);
`ifdef CGRA_TIMEOUT_EN
  assign bus.Timeout_Err      = terr_q;
`else
  assign bus.Timeout_Err      = 1'b0;
`endif

endmodule
